// File: rtl/cram_bank_responder_if.sv
// Two-initiator banked CRAM bus (ports A and B) between DMA masters and cram_bank_responder.
interface cram_bank_responder_if #(
  parameter int DATA_W = 32
);
  // A port presents a request when cs is one-hot. The request is taken at the
  // clock edge where ready is 1. While ready is 0 the initiator holds cs, wen,
  // addr and wdata unchanged. Read data returns one cycle later with a one-cycle
  // rvalid pulse.
  logic [3:0]          cs_a_i;
  logic [DATA_W/8-1:0] wen_a_i;
  logic [31:0]         addr_a_i;
  logic [DATA_W-1:0]   wdata_a_i;
  logic [DATA_W-1:0]   rdata_a_o;
  logic                rvalid_a_o;
  logic                ready_a_o;

  logic [3:0]          cs_b_i;
  logic [DATA_W/8-1:0] wen_b_i;
  logic [31:0]         addr_b_i;
  logic [DATA_W-1:0]   wdata_b_i;
  logic [DATA_W-1:0]   rdata_b_o;
  logic                rvalid_b_o;
  logic                ready_b_o;

  modport master (
    output cs_a_i, wen_a_i, addr_a_i, wdata_a_i,
    input  rdata_a_o, rvalid_a_o, ready_a_o,
    output cs_b_i, wen_b_i, addr_b_i, wdata_b_i,
    input  rdata_b_o, rvalid_b_o, ready_b_o
  );

  modport slave (
    input  cs_a_i, wen_a_i, addr_a_i, wdata_a_i,
    output rdata_a_o, rvalid_a_o, ready_a_o,
    input  cs_b_i, wen_b_i, addr_b_i, wdata_b_i,
    output rdata_b_o, rvalid_b_o, ready_b_o
  );
endinterface

// File: rtl/cram_bank_responder.sv
// Four-bank CRAM responder serving two ports with per-bank round-robin arbitration.
// Optional conflict counter enabled by macro CRAM_CONFLICT_CNT_EN.
module cram_bank_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int NBANK  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cram_bank_responder_if.slave bus,
  output logic [15:0]          conflict_cnt_o
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [NBANK][DEPTH];

  logic [NBANK-1:0]  prio_b;
  logic              valid_a, valid_b, conflict;
  logic              acc_a, acc_b, wr_a, wr_b, rd_a, rd_b;
  logic [1:0]        bank_a, bank_b;
  logic [ADDR_W-1:0] idx_a, idx_b;
  logic [DATA_W-1:0] rd_word_a, rd_word_b;

  function automatic logic is_onehot(input logic [3:0] cs);
    return (cs != 4'd0) && ((cs & (cs - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] bank_of(input logic [3:0] cs);
    case (cs)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign valid_a  = is_onehot(bus.cs_a_i);
  assign valid_b  = is_onehot(bus.cs_b_i);
  assign conflict = valid_a && valid_b && (bus.cs_a_i == bus.cs_b_i);

  // A prio_b bit of 1 means port B wins the next conflict on that bank.
  assign bus.ready_a_o = !(conflict && |(bus.cs_a_i & prio_b));
  assign bus.ready_b_o = !(conflict && |(bus.cs_b_i & ~prio_b));

  assign acc_a = valid_a && bus.ready_a_o;
  assign acc_b = valid_b && bus.ready_b_o;
  assign wr_a  = acc_a && (bus.wen_a_i != '0);
  assign wr_b  = acc_b && (bus.wen_b_i != '0);
  assign rd_a  = acc_a && (bus.wen_a_i == '0);
  assign rd_b  = acc_b && (bus.wen_b_i == '0);

  // The cs bit alone picks the bank; addr[11:10] is never decoded.
  assign bank_a = bank_of(bus.cs_a_i);
  assign bank_b = bank_of(bus.cs_b_i);
  assign idx_a  = bus.addr_a_i[ADDR_W+1:2];
  assign idx_b  = bus.addr_b_i[ADDR_W+1:2];

  assign rd_word_a = mem[bank_a][idx_a];
  assign rd_word_b = mem[bank_b][idx_b];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_a_i[31:ADDR_W+2], bus.addr_a_i[1:0],
                              bus.addr_b_i[31:ADDR_W+2], bus.addr_b_i[1:0]};

  // Accepted writes from both ports never share a bank, so no write collision.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NB; i++) begin
      if (wr_a && bus.wen_a_i[i]) mem[bank_a][idx_a][8*i +: 8] <= bus.wdata_a_i[8*i +: 8];
      if (wr_b && bus.wen_b_i[i]) mem[bank_b][idx_b][8*i +: 8] <= bus.wdata_b_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bus.rdata_a_o  <= '0;
      bus.rdata_b_o  <= '0;
      bus.rvalid_a_o <= 1'b0;
      bus.rvalid_b_o <= 1'b0;
      prio_b         <= '0;
    end else begin
      bus.rvalid_a_o <= rd_a;
      bus.rvalid_b_o <= rd_b;
      if (rd_a) bus.rdata_a_o <= rd_word_a;
      if (rd_b) bus.rdata_b_o <= rd_word_b;
      // Hand the contested bank's priority to the port that just lost.
      if (conflict) prio_b <= prio_b ^ bus.cs_a_i;
    end
  end

`ifdef CRAM_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule
